// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, widths and sizing helpers
// Contents:
//   UART_DATA_BITS   data bits per frame
//   uart_tx_state_t  transmitter FSM states (PARITY only with UART_TX_PARITY_EN)
//   tick_cnt_width   width of a counter that must hold 0..ticks_per_bit
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } uart_tx_state_t;

    function automatic int tick_cnt_width(input int ticks_per_bit);
        return $clog2(ticks_per_bit + 1);
    endfunction

endpackage

// File: rtl/uart_tx_ticked_if.sv
// rtl/uart_tx_ticked_if.sv - byte handshake between a producer and the UART transmitter
// Signals:
//   data   byte to transmit
//   valid  data is valid
//   ready  transmitter can accept a byte this cycle
// Modports: master (producer), slave (transmitter)
interface uart_tx_ticked_if;

    logic [uart_pkg::UART_DATA_BITS-1:0] data;
    logic                                valid;
    logic                                ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - counts tick pulses and flags the end of each UART bit
// Ports:
//   clk      system clock
//   rst      asynchronous active-high reset
//   tick     single-cycle bit-timing enable
//   clear    hold the count at zero (no bit in progress)
//   bit_end  high in the cycle whose tick completes TICKS_PER_BIT ticks
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int TICKS_PER_BIT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic clear,
    output logic bit_end
);

    localparam int CW = tick_cnt_width(TICKS_PER_BIT);
    localparam logic [CW-1:0] LAST_TICK = CW'(TICKS_PER_BIT - 1);

    logic [CW-1:0] tick_cnt;

    // Decoded straight from the tick so the owner can change its line on
    // the very edge that closes the bit; the owner registers the effect.
    assign bit_end = tick && !clear && (tick_cnt == LAST_TICK);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (clear || bit_end) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= tick_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/uart_tx_ticked.sv
// rtl/uart_tx_ticked.sv - tick-timed UART transmitter: start, 8 data LSB first, [parity], stop bit(s)
// Optional feature macro: UART_TX_PARITY_EN (adds an even parity bit after the data)
// Ports:
//   clk_i   system clock
//   rst_i   asynchronous active-high reset
//   tick_i  single-cycle bit-timing enable
//   bus     byte handshake (data, valid in; ready out)
//   tx_o    serial line, idle high
//   busy_o  a frame is armed or in flight
//   done_o  one-cycle pulse when the last stop bit completes
module uart_tx_ticked
    import uart_pkg::*;
#(
    parameter int TICKS_PER_BIT = 8,
    parameter int STOP_BITS     = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   tick_i,
    uart_tx_ticked_if.slave        bus,
    output logic                   tx_o,
    output logic                   busy_o,
    output logic                   done_o
);

    localparam logic [2:0] LAST_BIT  = 3'(UART_DATA_BITS - 1);
    localparam logic       STOP_LAST = (STOP_BITS == 2);

    uart_tx_state_t              state;
    logic [UART_DATA_BITS-1:0]   shift;
    logic [2:0]                  bit_cnt;
    logic                        stop_cnt;
    logic                        tx_q;
    logic                        ready_q;
    logic                        busy_q;
    logic                        done_q;
    logic                        bit_end;
    logic                        timer_clear;
`ifdef UART_TX_PARITY_EN
    logic                        parity_q;
`endif

    // No bit is being timed until the start bit begins; the ARM tick itself
    // is the zero point of the tick grid and must not count.
    assign timer_clear = (state == IDLE) || (state == ARM);

    uart_bit_timer #(
        .TICKS_PER_BIT (TICKS_PER_BIT)
    ) u_bit_timer (
        .clk     (clk_i),
        .rst     (rst_i),
        .tick    (tick_i),
        .clear   (timer_clear),
        .bit_end (bit_end)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            shift    <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            tx_q     <= 1'b1;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.valid) begin
                        shift   <= bus.data;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state   <= ARM;
`ifdef UART_TX_PARITY_EN
                        parity_q <= ^bus.data;
`endif
                    end
                end
                ARM: begin
                    if (tick_i) begin
                        tx_q  <= 1'b0;
                        state <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        tx_q    <= shift[0];
                        bit_cnt <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                            tx_q  <= parity_q;
                            state <= PARITY;
`else
                            tx_q     <= 1'b1;
                            stop_cnt <= 1'b0;
                            state    <= STOP;
`endif
                        end else begin
                            shift   <= shift >> 1;
                            tx_q    <= shift[1];
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        tx_q     <= 1'b1;
                        stop_cnt <= 1'b0;
                        state    <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        if (stop_cnt == STOP_LAST) begin
                            done_q  <= 1'b1;
                            ready_q <= 1'b1;
                            busy_q  <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            stop_cnt <= 1'b1;
                        end
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign tx_o      = tx_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign bus.ready = ready_q;

endmodule

// File: tb/tb_uart_tx_ticked.sv
// tb/tb_uart_tx_ticked.sv - scoreboard bench for uart_tx_ticked
module tb_uart_tx_ticked;

`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int CPB_A = 20;          // 4 ticks per bit, tick every 5 clks
    localparam int NB_A  = 10 + PAR;    // start + 8 data [+ parity] + 1 stop
    localparam int NB_B  = 11 + PAR;    // start + 8 data [+ parity] + 2 stop

    logic clk, rst;
    logic tick_a, tick_b;
    logic tx_a, busy_a, done_a;
    logic tx_b, busy_b, done_b;
    int   tick_ph;

    uart_tx_ticked_if bus_a();
    uart_tx_ticked_if bus_b();

    uart_tx_ticked #(.TICKS_PER_BIT(4), .STOP_BITS(1)) dut_a (
        .clk_i(clk), .rst_i(rst), .tick_i(tick_a), .bus(bus_a),
        .tx_o(tx_a), .busy_o(busy_a), .done_o(done_a)
    );

    uart_tx_ticked #(.TICKS_PER_BIT(1), .STOP_BITS(2)) dut_b (
        .clk_i(clk), .rst_i(rst), .tick_i(tick_b), .bus(bus_b),
        .tx_o(tx_b), .busy_o(busy_b), .done_o(done_b)
    );

    int n_checks, n_fail;
    int frames_a, done_cnt_a;
    logic last_par_a;
    logic [7:0] sb_a[$];
    logic [7:0] sb_b[$];

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // tick_a: one-cycle pulse every 5 clks; tick_b: every clk
    initial begin
        tick_ph = 0;
        tick_a  = 1'b0;
        tick_b  = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            tick_ph = (tick_ph == 4) ? 0 : tick_ph + 1;
            tick_a  = (tick_ph == 0);
        end
    end

    initial begin
        done_cnt_a = 0;
        forever begin
            @(negedge clk);
            if (done_a === 1'b1) done_cnt_a++;
        end
    end

    // Frame monitor for dut_a: samples every clk of the frame, pops the scoreboard
    initial begin : mon_a
        logic prev;
        logic [NB_A-1:0] bitv;
        logic [7:0] exp;
        bit width_ok, early_done, aborted;
        prev = 1'b1;
        frames_a = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev = 1'b1;
            end else if (prev && tx_a === 1'b0) begin
                width_ok = 1; early_done = 0; aborted = 0; bitv = '0;
                for (int i = 0; i < NB_A * CPB_A; i++) begin
                    if (i > 0) @(negedge clk);
                    if (rst) begin aborted = 1; break; end
                    if (i % CPB_A == 0) bitv[i / CPB_A] = tx_a;
                    else if (tx_a !== bitv[i / CPB_A]) width_ok = 0;
                    if (done_a === 1'b1) early_done = 1;
                end
                if (!aborted) begin
                    @(negedge clk);
                    exp = 8'hxx;
                    n_checks++; if (sb_a.size() == 0) begin n_fail++; $display("FAIL mon_a_unexpected_frame: got frame 0x%0h expected none", bitv[8:1]); end
                    else exp = sb_a.pop_front();
                    n_checks++; if (bitv[0] !== 1'b0) begin n_fail++; $display("FAIL mon_a_start: got %b expected 0", bitv[0]); end
                    n_checks++; if (bitv[8:1] !== exp) begin n_fail++; $display("FAIL mon_a_data: got 0x%0h expected 0x%0h", bitv[8:1], exp); end
`ifdef UART_TX_PARITY_EN
                    last_par_a = bitv[9];
                    n_checks++; if (bitv[9] !== ^exp) begin n_fail++; $display("FAIL mon_a_parity: got %b expected %b", bitv[9], ^exp); end
`endif
                    n_checks++; if (bitv[NB_A-1] !== 1'b1) begin n_fail++; $display("FAIL mon_a_stop: got %b expected 1", bitv[NB_A-1]); end
                    n_checks++; if (!width_ok) begin n_fail++; $display("FAIL mon_a_bit_width: got uneven bits expected %0d clks each", CPB_A); end
                    n_checks++; if (early_done) begin n_fail++; $display("FAIL mon_a_early_done: got done inside frame expected none"); end
                    n_checks++; if (done_a !== 1'b1) begin n_fail++; $display("FAIL mon_a_done_pos: got %b expected 1 after last stop", done_a); end
                    n_checks++; if (bus_a.ready !== 1'b1) begin n_fail++; $display("FAIL mon_a_ready_at_done: got %b expected 1", bus_a.ready); end
                    frames_a++;
                end
                prev = aborted ? 1'b1 : tx_a;
            end else begin
                prev = tx_a;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic send_a(input logic [7:0] b, output bit ok);
        ok = 0;
        @(posedge clk); #1;
        bus_a.data = b; bus_a.valid = 1'b1;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (bus_a.ready === 1'b1) begin ok = 1; break; end
        end
        if (ok) begin
            @(posedge clk);
            sb_a.push_back(b);
        end
        #1 bus_a.valid = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] b, output bit ok);
        ok = 0;
        @(posedge clk); #1;
        bus_b.data = b; bus_b.valid = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (bus_b.ready === 1'b1) begin ok = 1; break; end
        end
        if (ok) begin
            @(posedge clk);
            sb_b.push_back(b);
        end
        #1 bus_b.valid = 1'b0;
    endtask

    task automatic wait_frames_a(input int target, input int budget, output bit ok);
        ok = 0;
        for (int n = 0; n < budget; n++) begin
            if (frames_a >= target) break;
            @(negedge clk);
        end
        if (frames_a >= target) ok = 1;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++; if (tx_a !== 1'b1) begin n_fail++; $display("FAIL reset_tx_a: got %b expected 1", tx_a); end
        n_checks++; if (bus_a.ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_a: got %b expected 1", bus_a.ready); end
        n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy_a: got %b expected 0", busy_a); end
        n_checks++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL reset_done_a: got %b expected 0", done_a); end
        @(posedge clk); #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (tx_b !== 1'b1) begin n_fail++; $display("FAIL reset_tx_b: got %b expected 1", tx_b); end
        n_checks++; if (bus_b.ready !== 1'b1 || busy_b !== 1'b0) begin n_fail++; $display("FAIL idle_b: got ready %b busy %b expected 1 0", bus_b.ready, busy_b); end
    endtask

    task automatic test_frame_a5();
        bit ok; int f0, dc0;
        f0 = frames_a; dc0 = done_cnt_a;
        send_a(8'hA5, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL a5_accept: got no ready expected ready"); end
        @(negedge clk);
        n_checks++; if (busy_a !== 1'b1 || bus_a.ready !== 1'b0) begin n_fail++; $display("FAIL a5_armed: got busy %b ready %b expected 1 0", busy_a, bus_a.ready); end
        @(posedge clk); #1 bus_a.data = 8'hFF;
        wait_frames_a(f0 + 1, 600, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL a5_frame: got %0d frames expected %0d", frames_a, f0 + 1); end
        repeat (3) @(negedge clk);
        n_checks++; if (done_cnt_a !== dc0 + 1) begin n_fail++; $display("FAIL a5_done_count: got %0d expected %0d", done_cnt_a, dc0 + 1); end
    endtask

    task automatic test_tick_same_cycle();
        bit ok; int f0, t_low;
        f0 = frames_a; t_low = -1; ok = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (tick_ph == 4) begin ok = 1; break; end
        end
        @(posedge clk); #1;
        bus_a.data = 8'h96; bus_a.valid = 1'b1;
        @(negedge clk);
        n_checks++; if (tick_a !== 1'b1 || bus_a.ready !== 1'b1 || !ok) begin n_fail++; $display("FAIL tick_align: got tick %b ready %b expected 1 1", tick_a, bus_a.ready); end
        @(posedge clk);
        sb_a.push_back(8'h96);
        #1 bus_a.valid = 1'b0;
        for (int n = 1; n < 20; n++) begin
            @(negedge clk);
            if (tx_a === 1'b0) begin t_low = n; break; end
        end
        n_checks++; if (t_low != 6) begin n_fail++; $display("FAIL tick_ignored: got start at clk %0d expected 6", t_low); end
        wait_frames_a(f0 + 1, 600, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL tick_frame: got %0d frames expected %0d", frames_a, f0 + 1); end
    endtask

    task automatic test_back_to_back();
        bit ok; int f0, t_first, t_low;
        f0 = frames_a; t_first = -1; t_low = -1; ok = 0;
        @(posedge clk); #1;
        bus_a.data = 8'h00; bus_a.valid = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bus_a.ready === 1'b1) begin ok = 1; break; end
        end
        @(posedge clk);
        sb_a.push_back(8'h00);
        #1 bus_a.data = 8'hFF;
        ok = 0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (bus_a.ready === 1'b1) begin ok = 1; break; end
        end
        n_checks++; if (!ok || done_a !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_with_done: got ready %b done %b expected 1 1", bus_a.ready, done_a); end
        @(posedge clk);
        sb_a.push_back(8'hFF);
        #1 bus_a.valid = 1'b0;
        for (int n = 1; n < 50; n++) begin
            @(negedge clk);
            if (tick_a === 1'b1 && t_first < 0) t_first = n;
            if (tx_a === 1'b0) begin t_low = n; break; end
        end
        n_checks++; if (t_first < 0 || t_low != t_first + 1) begin n_fail++; $display("FAIL b2b_start_align: got start %0d first tick %0d expected tick+1", t_low, t_first); end
        wait_frames_a(f0 + 2, 600, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL b2b_frames: got %0d expected %0d", frames_a, f0 + 2); end
        n_checks++; if (sb_a.size() != 0) begin n_fail++; $display("FAIL b2b_leftover: got %0d queued expected 0", sb_a.size()); end
    endtask

    task automatic test_reset_mid_frame();
        bit ok; int f0, dc0;
        f0 = frames_a; ok = 0;
        send_a(8'h52, ok);
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (tx_a === 1'b0) begin ok = 1; break; end
        end
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rst_start: got no start bit expected start"); end
        repeat (90) @(negedge clk);
        n_checks++; if (tx_a !== 1'b0) begin n_fail++; $display("FAIL rst_bit3_level: got %b expected 0", tx_a); end
        dc0 = done_cnt_a;
        @(posedge clk); #2 rst = 1'b1;
        #1;
        n_checks++; if (tx_a !== 1'b1) begin n_fail++; $display("FAIL rst_async_tx: got %b expected 1", tx_a); end
        n_checks++; if (busy_a !== 1'b0 || bus_a.ready !== 1'b1) begin n_fail++; $display("FAIL rst_async_flags: got busy %b ready %b expected 0 1", busy_a, bus_a.ready); end
        @(posedge clk); #2 rst = 1'b0;
        if (sb_a.size() > 0) void'(sb_a.pop_front());
        repeat (5) @(negedge clk);
        n_checks++; if (done_cnt_a != dc0 || frames_a != f0) begin n_fail++; $display("FAIL rst_no_done: got done %0d frames %0d expected %0d %0d", done_cnt_a, frames_a, dc0, f0); end
        send_a(8'h3C, ok);
        wait_frames_a(f0 + 1, 600, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rst_next_frame: got %0d expected %0d", frames_a, f0 + 1); end
    endtask

    task automatic test_two_stop();
        bit ok, early; logic [NB_B-1:0] s; logic [7:0] exp;
        early = 0; exp = 8'hxx; s = '0;
        send_b(8'h81, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL b_accept: got no ready expected ready"); end
        ok = 0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (tx_b === 1'b0) begin ok = 1; break; end
        end
        n_checks++; if (!ok) begin n_fail++; $display("FAIL b_start: got no start bit expected start"); end
        for (int i = 0; i < NB_B; i++) begin
            if (i > 0) @(negedge clk);
            s[i] = tx_b;
            if (done_b === 1'b1) early = 1;
        end
        @(negedge clk);
        if (sb_b.size() > 0) exp = sb_b.pop_front();
        n_checks++; if (s[0] !== 1'b0 || s[8:1] !== exp) begin n_fail++; $display("FAIL b_data: got start %b data 0x%0h expected 0 0x%0h", s[0], s[8:1], exp); end
`ifdef UART_TX_PARITY_EN
        n_checks++; if (s[9] !== 1'b0) begin n_fail++; $display("FAIL b_parity: got %b expected 0", s[9]); end
`endif
        n_checks++; if (s[NB_B-1:NB_B-2] !== 2'b11 || early) begin n_fail++; $display("FAIL b_two_stop: got stop %b early done %b expected 11 0", s[NB_B-1:NB_B-2], early); end
        n_checks++; if (done_b !== 1'b1 || bus_b.ready !== 1'b1) begin n_fail++; $display("FAIL b_done_len: got done %b ready %b expected 1 1", done_b, bus_b.ready); end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        bit ok; int f0;
        f0 = frames_a;
        send_a(8'h07, ok);
        wait_frames_a(f0 + 1, 600, ok);
        n_checks++; if (!ok || last_par_a !== 1'b1) begin n_fail++; $display("FAIL parity_07: got %b expected 1", last_par_a); end
        send_a(8'h03, ok);
        wait_frames_a(f0 + 2, 600, ok);
        n_checks++; if (!ok || last_par_a !== 1'b0) begin n_fail++; $display("FAIL parity_03: got %b expected 0", last_par_a); end
    endtask
`endif

    initial begin
        n_checks = 0; n_fail = 0;
        rst = 1'b1;
        last_par_a = 1'bx;
        bus_a.data = 8'h00; bus_a.valid = 1'b0;
        bus_b.data = 8'h00; bus_b.valid = 1'b0;
        test_reset();
        test_frame_a5();
        test_tick_same_cycle();
        test_back_to_back();
        test_reset_mid_frame();
        test_two_stop();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
